// File: rtl/fpu_req_ctrl_if.sv
// Bundle of request, response and downstream-FPU signals for fpu_req_ctrl.
// The controller connects through the slave modport; the requester/FPU side uses master.
interface fpu_req_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [63:0] req_din1;
    logic [63:0] req_din2;

    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_result;
    logic [3:0]  resp_cmd;
    logic        resp_err;

    logic [3:0]  fpu_cmd;
    logic [63:0] fpu_din1;
    logic [63:0] fpu_din2;
    logic        fpu_dval;
    logic [63:0] fpu_result;
    logic        fpu_rdy;

    logic        busy;

    modport slave (
        input  req_valid, req_cmd, req_din1, req_din2,
        input  resp_ready,
        input  fpu_result, fpu_rdy,
        output req_ready,
        output resp_valid, resp_result, resp_cmd, resp_err,
        output fpu_cmd, fpu_din1, fpu_din2, fpu_dval,
        output busy
    );

    modport master (
        output req_valid, req_cmd, req_din1, req_din2,
        output resp_ready,
        output fpu_result, fpu_rdy,
        input  req_ready,
        input  resp_valid, resp_result, resp_cmd, resp_err,
        input  fpu_cmd, fpu_din1, fpu_din2, fpu_dval,
        input  busy
    );
endinterface

// File: rtl/fpu_req_ctrl.sv
// Single-outstanding request controller in front of an FPU: accept, issue, wait, respond.
// Optional WAIT-state timeout is enabled by defining FPU_REQ_CTRL_TIMEOUT_EN.
module fpu_req_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic           clk,
    input logic           rst_n,
    fpu_req_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  cmd_q;
    logic [63:0] din1_q;
    logic [63:0] din2_q;
    logic [63:0] result_q;
    logic        err_q;
    logic        rdy_armed;

    logic        cmd_ok;
    logic        rdy_hit;
    logic        timeout_hit;

    if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("fpu_req_ctrl: TIMEOUT_CYCLES must lie in 4..65535");
    end

    function automatic logic is_fpu_cmd(input logic [3:0] c);
        case (c)
            4'b0001, 4'b0010, 4'b0011,
            4'b0101, 4'b0110, 4'b0111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    assign cmd_ok  = is_fpu_cmd(bus.req_cmd);
    // rdy_armed is low during the first WAIT cycle so a ready left over from a previous op is ignored
    assign rdy_hit = (state == ST_WAIT) && rdy_armed && bus.fpu_rdy;

`ifdef FPU_REQ_CTRL_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // wait_cnt holds the number of completed WAIT cycles, so the last allowed cycle sees TIMEOUT_LAST
    assign timeout_hit = (state == ST_WAIT) && (wait_cnt == TIMEOUT_LAST) && !rdy_hit;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_nxt = cmd_ok ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (rdy_hit || timeout_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            din1_q    <= '0;
            din2_q    <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            rdy_armed <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rdy_armed <= 1'b0;
                    if (bus.req_valid) begin
                        cmd_q    <= bus.req_cmd;
                        din1_q   <= bus.req_din1;
                        din2_q   <= bus.req_din2;
                        result_q <= '0;
                        err_q    <= !cmd_ok;
                    end
                end
                ST_ISSUE: begin
                    rdy_armed <= 1'b0;
                end
                ST_WAIT: begin
                    rdy_armed <= 1'b1;
                    if (rdy_hit) begin
                        result_q <= bus.fpu_result;
                        err_q    <= 1'b0;
                    end else if (timeout_hit) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Response payload is only visible in RESP; the FPU operands stay up from ISSUE to RESP exit
    always_comb begin
        bus.req_ready   = (state == ST_IDLE) && rst_n;
        bus.busy        = (state != ST_IDLE);
        bus.fpu_dval    = (state == ST_ISSUE);
        bus.fpu_cmd     = '0;
        bus.fpu_din1    = '0;
        bus.fpu_din2    = '0;
        bus.resp_valid  = 1'b0;
        bus.resp_result = '0;
        bus.resp_cmd    = '0;
        bus.resp_err    = 1'b0;
        if (state != ST_IDLE) begin
            bus.fpu_cmd  = cmd_q;
            bus.fpu_din1 = din1_q;
            bus.fpu_din2 = din2_q;
        end
        if (state == ST_RESP) begin
            bus.resp_valid  = 1'b1;
            bus.resp_result = result_q;
            bus.resp_cmd    = cmd_q;
            bus.resp_err    = err_q;
        end
    end

endmodule

// File: doc/fpu_req_ctrl.md
FPU_REQ_CTRL -- requirements
Module: fpu_req_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 1024, maximum WAIT cycles before an operation aborts (range 4..65535).
REQ-002 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports: req_valid  input  1; req_ready  output  1; request handshake.
REQ-005 SHALL have ports: req_cmd  input  4; req_din1  input  64; req_din2  input  64; request payload.
REQ-006 SHALL have ports: resp_valid  output  1; resp_ready  input  1; response handshake.
REQ-007 SHALL have ports: resp_result  output  64; resp_cmd  output  4; resp_err  output  1; response payload.
REQ-008 SHALL have ports: fpu_cmd  output  4; fpu_din1  output  64; fpu_din2  output  64; fpu_dval  output  1; drive the downstream FPU top.
REQ-009 SHALL have ports: fpu_result  input  64; fpu_rdy  input  1; returned from the FPU top.
REQ-010 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-012 SHALL assert req_ready only in IDLE; transfer occurs on req_valid & req_ready.
REQ-013 SHALL, on transfer, register cmd/din1/din2 and go to ISSUE if cmd is in {0001,0010,0011,0101,0110,0111}, else go directly to RESP with resp_err=1, resp_result=0.
REQ-014 SHALL drive fpu_cmd/fpu_din1/fpu_din2 from the registered request, stable from ISSUE through the RESP-exit cycle; 0 in IDLE.
REQ-015 SHALL assert fpu_dval for exactly one cycle (ISSUE), then go to WAIT; never assert it for an invalid cmd.
REQ-016 SHALL ignore fpu_rdy in ISSUE and in the first WAIT cycle (stale-ready guard); sample it from the second WAIT cycle onward.
REQ-017 SHALL, on a sampled fpu_rdy=1, capture fpu_result into resp_result, set resp_err=0 and go to RESP.
REQ-018 SHALL assert resp_valid only in RESP, with resp_result/resp_cmd/resp_err held stable until resp_valid & resp_ready, then return to IDLE.
REQ-019 SHALL give minimum latency of 4 cycles from request transfer to resp_valid (valid cmd, fpu_rdy high at first sample); invalid cmd: resp_valid on the cycle after transfer.
REQ-020 SHALL not accept a new request in the RESP-exit cycle (req_ready rises the following cycle in IDLE).
REQ-021 SHALL set resp_cmd to the registered req_cmd for all responses, including errors.

Reset
REQ-022 SHALL, when rst_n=0 at a rising edge, enter IDLE regardless of state, including mid-WAIT; no response is produced for the aborted operation.
REQ-023 SHALL reset values: req_ready=0 while rst_n=0 then 1 in IDLE; resp_valid=0, resp_result=0, resp_cmd=0, resp_err=0, fpu_dval=0, fpu_cmd=0, fpu_din1=0, fpu_din2=0, busy=0, timeout counter=0.

Configuration
REQ-024 SHALL, with FPU_REQ_CTRL_TIMEOUT_EN defined, include a 16-bit WAIT counter cleared on ISSUE; counting WAIT cycles, reaching TIMEOUT_CYCLES without sampled fpu_rdy goes to RESP with resp_err=1, resp_result=0.
REQ-025 SHALL, when fpu_rdy is sampled high on the same cycle the counter reaches TIMEOUT_CYCLES, treat it as success (rdy wins).
REQ-026 SHALL, without FPU_REQ_CTRL_TIMEOUT_EN, omit the counter and wait in WAIT indefinitely; TIMEOUT_CYCLES is then unused.

Verification
REQ-027 SHALL cover: cmd=0001, din1=0x3F800000, din2=0x40000000 -> one fpu_dval pulse, resp_result[31:0]=0x40400000, resp_err=0, resp_cmd=0001.
REQ-028 SHALL cover: cmd=0110, din1=0x4000000000000000, din2=0x4008000000000000 -> resp_result=0x4018000000000000, resp_err=0.
REQ-029 SHALL cover: cmd=0100 -> no fpu_dval, resp_valid next cycle with resp_err=1, resp_result=0, resp_cmd=0100.
REQ-030 SHALL cover: resp_ready held low 10 cycles after resp_valid -> payload stable, req_ready=0, busy=1 throughout; IDLE one cycle after resp_ready=1.
REQ-031 SHALL cover (FPU_REQ_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16): fpu_rdy tied 0 -> resp_err=1, resp_result=0 after 16 WAIT cycles; fpu_rdy=1 on the 16th -> success.
REQ-032 SHALL cover: rst_n=0 for one cycle mid-WAIT -> next cycle IDLE, all outputs at reset values, no resp_valid; a following request completes normally.
